// File: rtl/xadc_drp_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// xadc_pkg
//   Shared types and constants for the XADC DRP scheduler:
//   - FSM state encoding (IDLE / SAMPLE_WAIT / CFG_WAIT)
//   - DRP bus widths and well-known XADC channel numbers
//   - the 22-bit sample record carried by the stream FIFO
//   - small helpers to build DRP addresses and sample records
// -----------------------------------------------------------------------------
package xadc_pkg;

  localparam int DRP_ADDR_W = 7;
  localparam int DRP_DATA_W = 16;
  localparam int CHAN_W     = 5;

  localparam logic [CHAN_W-1:0] CHAN_TEMP   = 5'h00;
  localparam logic [CHAN_W-1:0] CHAN_VPVN   = 5'h03;
  localparam logic [CHAN_W-1:0] CHAN_VAUX5  = 5'h15;
  localparam logic [CHAN_W-1:0] CHAN_VAUX12 = 5'h1C;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SAMPLE_WAIT = 2'd1,
    CFG_WAIT    = 2'd2
  } state_t;

  // One buffered conversion result: code, channel and end-of-frame marker.
  typedef struct packed {
    logic [DRP_DATA_W-1:0] data;
    logic [CHAN_W-1:0]     chan;
    logic                  last;
  } sample_t;

  localparam int SAMPLE_W = $bits(sample_t);

  // Status registers for channel N live at DRP address N.
  function automatic logic [DRP_ADDR_W-1:0] chan_to_addr(input logic [CHAN_W-1:0] chan);
    return {2'b00, chan};
  endfunction

  function automatic sample_t make_sample(input logic [DRP_DATA_W-1:0] data,
                                          input logic [CHAN_W-1:0]     chan,
                                          input logic [CHAN_W-1:0]     last_chan);
    sample_t s;
    s.data = data;
    s.chan = chan;
    s.last = (chan == last_chan);
    return s;
  endfunction

endpackage

// File: rtl/xadc_drp_scheduler_sample_fifo.sv
// -----------------------------------------------------------------------------
// xadc_sample_fifo
//   Two-entry stream FIFO for XADC samples. The head entry is held in a
//   register that drives the output directly, so o_data is stable while
//   o_valid && !i_ready. A push and a pop in the same cycle are accepted even
//   when full (occupancy stays at two).
//
// Ports
//   clk, resetn  clock, asynchronous active-low reset
//   i_push       write i_data (ignored when full and not popping)
//   i_data       sample record to store
//   o_full       both entries occupied
//   o_valid      head entry is valid
//   o_data       head entry
//   i_ready      consumer accepts head entry this cycle
// -----------------------------------------------------------------------------
module xadc_sample_fifo
  import xadc_pkg::*;
(
  input  logic    clk,
  input  logic    resetn,
  input  logic    i_push,
  input  sample_t i_data,
  output logic    o_full,
  output logic    o_valid,
  output sample_t o_data,
  input  logic    i_ready
);

  sample_t    r_head;
  sample_t    r_tail;
  logic [1:0] r_count;
  logic       w_pop;
  logic       w_push;

  assign w_pop  = (r_count != 2'd0) && i_ready;
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_data;
          else                 r_tail <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new entry goes behind whatever remains.
          if (r_count == 2'd1) begin
            r_head <= i_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_full  = (r_count == 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_head;

endmodule

// File: rtl/xadc_drp_scheduler.sv
// -----------------------------------------------------------------------------
// xadc_drp_scheduler
//   Sole master of the XADC DRP port. Arbitrates between end-of-conversion
//   readout (status register read per EOC, result pushed into a 2-entry
//   sample stream) and single host configuration reads/writes. EOC readout
//   has priority unless the sample buffer is full.
//
// Build option
//   XADC_DRP_TIMEOUT_EN : when defined, a wait for drdy is aborted after
//   TIMEOUT_CYCLES cycles (counted from den). A config abort returns
//   cfg_ack with cfg_err=1 and cfg_rdata=16'hDEAD; a sample abort drops the
//   sample and sets overflow. When undefined, waits are unbounded and
//   cfg_err is always 0.
//
// Ports
//   clk, resetn        DRP/system clock, asynchronous active-low reset
//   eoc_in, channel_in XADC end-of-conversion pulse and converted channel
//   drp_*              DRP master interface (den is a one-cycle pulse)
//   m_valid/m_ready    sample stream handshake; m_data/m_chan/m_last payload
//   cfg_req..cfg_wdata host request (held until cfg_ack)
//   cfg_ack/rdata/err  one-cycle completion with read data and abort flag
//   overflow           sticky: a sample was lost
// -----------------------------------------------------------------------------
module xadc_drp_scheduler
  import xadc_pkg::*;
#(
  parameter logic [CHAN_W-1:0] LAST_CHANNEL   = 5'h1C,
  parameter int                TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  eoc_in,
  input  logic [CHAN_W-1:0]     channel_in,
  output logic                  drp_den,
  output logic                  drp_dwe,
  output logic [DRP_ADDR_W-1:0] drp_daddr,
  output logic [DRP_DATA_W-1:0] drp_di,
  input  logic [DRP_DATA_W-1:0] drp_do,
  input  logic                  drp_drdy,
  output logic                  m_valid,
  output logic [DRP_DATA_W-1:0] m_data,
  output logic [CHAN_W-1:0]     m_chan,
  output logic                  m_last,
  input  logic                  m_ready,
  input  logic                  cfg_req,
  input  logic                  cfg_we,
  input  logic [DRP_ADDR_W-1:0] cfg_addr,
  input  logic [DRP_DATA_W-1:0] cfg_wdata,
  output logic                  cfg_ack,
  output logic [DRP_DATA_W-1:0] cfg_rdata,
  output logic                  cfg_err,
  output logic                  overflow
);

  state_t            r_state;
  logic              r_pend;
  logic [CHAN_W-1:0] r_pend_chan;
  logic [CHAN_W-1:0] r_samp_chan;

  logic              w_eoc_avail;
  logic [CHAN_W-1:0] w_eoc_chan;
  logic              w_issue_sample;
  logic              w_issue_cfg;
  logic              w_push;
  sample_t           w_push_data;
  sample_t           w_fifo_data;
  logic              w_fifo_full;

`ifdef XADC_DRP_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_tmo_hit;

  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] w_unused_tmo;
  assign w_unused_tmo = TIMEOUT_CYCLES;
`endif

  // An EOC arriving this very cycle is eligible immediately, so a
  // simultaneous cfg_req still loses to it. An older pending EOC goes first.
  assign w_eoc_avail    = r_pend | eoc_in;
  assign w_eoc_chan     = r_pend ? r_pend_chan : channel_in;
  assign w_issue_sample = (r_state == IDLE) && w_eoc_avail && !w_fifo_full;
  // cfg_ack is high in the first IDLE cycle after completion while the host
  // has not yet seen it; masking the still-held request avoids a repeat.
  assign w_issue_cfg    = (r_state == IDLE) && !w_issue_sample && cfg_req && !cfg_ack;

  // Push is combinational on drdy so m_valid rises the cycle after drdy.
  assign w_push      = (r_state == SAMPLE_WAIT) && drp_drdy;
  assign w_push_data = make_sample(drp_do, r_samp_chan, LAST_CHANNEL);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_pend      <= 1'b0;
      r_pend_chan <= '0;
      r_samp_chan <= '0;
      drp_den     <= 1'b0;
      drp_dwe     <= 1'b0;
      drp_daddr   <= '0;
      drp_di      <= '0;
      cfg_ack     <= 1'b0;
      cfg_rdata   <= '0;
      cfg_err     <= 1'b0;
      overflow    <= 1'b0;
`ifdef XADC_DRP_TIMEOUT_EN
      r_tmo_cnt   <= '0;
`endif
    end else begin
      drp_den <= 1'b0;
      drp_dwe <= 1'b0;
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;

      // Pending EOC bookkeeping. If the pending one is issued while a new
      // EOC arrives, the new one becomes pending and nothing is lost.
      if (eoc_in) begin
        r_pend_chan <= channel_in;
        r_pend      <= !(w_issue_sample && !r_pend);
        if (r_pend && !w_issue_sample) overflow <= 1'b1;
      end else if (w_issue_sample) begin
        r_pend <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_issue_sample) begin
            drp_den     <= 1'b1;
            drp_dwe     <= 1'b0;
            drp_daddr   <= chan_to_addr(w_eoc_chan);
            r_samp_chan <= w_eoc_chan;
            r_state     <= SAMPLE_WAIT;
`ifdef XADC_DRP_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
          end else if (w_issue_cfg) begin
            drp_den   <= 1'b1;
            drp_dwe   <= cfg_we;
            drp_daddr <= cfg_addr;
            drp_di    <= cfg_wdata;
            r_state   <= CFG_WAIT;
`ifdef XADC_DRP_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
          end
        end

        SAMPLE_WAIT: begin
          if (drp_drdy) begin
            r_state <= IDLE;
          end
`ifdef XADC_DRP_TIMEOUT_EN
          else if (w_tmo_hit) begin
            overflow <= 1'b1;
            r_state  <= IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end

        CFG_WAIT: begin
          if (drp_drdy) begin
            cfg_ack   <= 1'b1;
            cfg_rdata <= drp_do;
            r_state   <= IDLE;
          end
`ifdef XADC_DRP_TIMEOUT_EN
          else if (w_tmo_hit) begin
            cfg_ack   <= 1'b1;
            cfg_err   <= 1'b1;
            cfg_rdata <= 16'hDEAD;
            r_state   <= IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  xadc_sample_fifo u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .o_full  (w_fifo_full),
    .o_valid (m_valid),
    .o_data  (w_fifo_data),
    .i_ready (m_ready)
  );

  assign m_data = w_fifo_data.data;
  assign m_chan = w_fifo_data.chan;
  assign m_last = w_fifo_data.last;

endmodule
